lsu_mem_master: RTL

- Initiator side of the single-port data RAM bus (we/addr/wdata/rdata, word-addressed by addr[31:2], combinational read, write on posedge clk).
- Accepts load/store requests from the CPU memory stage and handles RISC-V byte, halfword and word access with sign or zero extension.
- Performs read-modify-write for sub-word stores, since the RAM has no byte enables.
- Returns one response per request over a valid/ready handshake.

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/lsu_lane_align.sv | 56 +++++
 rtl/lsu_mem_master.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 access sizes,
// LSU state encoding and request legality helpers.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    // Unsigned variants only make sense for loads.
    function automatic logic f3_legal(input logic [2:0] funct3, input logic is_store);
        logic ok_s;
        case (funct3)
            F3_B, F3_H, F3_W: ok_s = 1'b1;
            F3_BU, F3_HU:     ok_s = !is_store;
            default:          ok_s = 1'b0;
        endcase
        return ok_s;
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad_s;
        case (funct3)
            F3_H, F3_HU: bad_s = addr_lo[0];
            F3_W:        bad_s = (addr_lo != 2'b00);
            default:     bad_s = 1'b0;
        endcase
        return bad_s;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane steering between a 32-bit RAM word and the CPU:
// extended load extraction and read-modify-write merge for sub-word stores.
module lsu_lane_align
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed lanes out of the word.
    always_comb begin
        byte_s = word[{addr_lo, 3'b000} +: 8];
        if (addr_lo[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
    end

    // Load result with sign or zero extension.
    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
            F3_H:    load_data = {{16{half_s[15]}}, half_s};
            F3_W:    load_data = word;
            F3_BU:   load_data = {24'd0, byte_s};
            F3_HU:   load_data = {16'd0, half_s};
            default: load_data = 32'd0;
        endcase
    end

    // Store merge: new data replaces only its lane, other bytes kept.
    always_comb begin
        merged = word;
        case (funct3)
            F3_B: merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (addr_lo[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            F3_W:    merged = wdata;
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator on the single-port data RAM: one request at a time,
// sub-word stores via read-modify-write, one response per request.
module lsu_mem_master
    import riscv_pkg::*;
#(
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i
);

    localparam logic [32:0] MEM_LO   = {1'b0, MEM_BASE};
    localparam logic [32:0] MEM_SPAN = 33'(MEM_WORDS) * 33'd4;

    lsu_state_e  state_r, state_nx_s;
    logic        ready_r, ready_nx_s;
    logic        valid_r, valid_nx_s;
    logic [31:0] rdata_r, rdata_nx_s;
    logic        err_r, err_nx_s;
    logic        ram_we_r, ram_we_nx_s;
    logic [31:0] ram_addr_r, ram_addr_nx_s;
    logic [31:0] ram_wdata_r, ram_wdata_nx_s;

    logic        we_r;
    logic [2:0]  f3_r;
    logic [1:0]  addr_lo_r;
    logic [31:0] wdata_r;

    logic        accept_s;
    logic [32:0] offset_s;
    logic        req_err_s;
    logic [31:0] load_data_s;
    logic [31:0] merged_s;

    assign accept_s = req_valid_i && ready_r;

    // Below-base addresses wrap to a huge offset, so one compare covers both ends.
    always_comb begin
        offset_s  = {1'b0, req_addr_i} - MEM_LO;
        req_err_s = (offset_s >= MEM_SPAN)
                 || misaligned(req_funct3_i, req_addr_i[1:0])
                 || !f3_legal(req_funct3_i, req_we_i);
    end

    lsu_lane_align u_lane_align (
        .word      (ram_rdata_i),
        .addr_lo   (addr_lo_r),
        .funct3    (f3_r),
        .wdata     (wdata_r),
        .load_data (load_data_s),
        .merged    (merged_s)
    );

    // Next-state and next-output logic; all outputs come from registers.
    always_comb begin
        state_nx_s     = state_r;
        ready_nx_s     = ready_r;
        valid_nx_s     = valid_r;
        rdata_nx_s     = rdata_r;
        err_nx_s       = err_r;
        ram_we_nx_s    = 1'b0;
        ram_addr_nx_s  = ram_addr_r;
        ram_wdata_nx_s = ram_wdata_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    ready_nx_s = 1'b0;
                    if (req_err_s) begin
                        state_nx_s = RESP;
                        valid_nx_s = 1'b1;
                        rdata_nx_s = 32'd0;
                        err_nx_s   = 1'b1;
                    end else begin
                        state_nx_s    = ACCESS;
                        ram_addr_nx_s = {req_addr_i[31:2], 2'b00};
                        if (req_we_i && (req_funct3_i == F3_W)) begin
                            ram_we_nx_s    = 1'b1;
                            ram_wdata_nx_s = req_wdata_i;
                        end else begin
                            ram_we_nx_s = 1'b0;
                        end
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ACCESS: begin
                if (!we_r) begin
                    state_nx_s = RESP;
                    valid_nx_s = 1'b1;
                    rdata_nx_s = load_data_s;
                    err_nx_s   = 1'b0;
                end else if (f3_r == F3_W) begin
                    state_nx_s = RESP;
                    valid_nx_s = 1'b1;
                    rdata_nx_s = 32'd0;
                    err_nx_s   = 1'b0;
                end else begin
                    // Old word is on ram_rdata_i now; merge it for the write cycle.
                    state_nx_s     = WRITE;
                    ram_we_nx_s    = 1'b1;
                    ram_wdata_nx_s = merged_s;
                end
            end
            WRITE: begin
                state_nx_s = RESP;
                valid_nx_s = 1'b1;
                rdata_nx_s = 32'd0;
                err_nx_s   = 1'b0;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_nx_s = IDLE;
                    ready_nx_s = 1'b1;
                    valid_nx_s = 1'b0;
                    rdata_nx_s = 32'd0;
                    err_nx_s   = 1'b0;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: begin
                state_nx_s = IDLE;
                ready_nx_s = 1'b1;
                valid_nx_s = 1'b0;
                rdata_nx_s = 32'd0;
                err_nx_s   = 1'b0;
            end
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ready_r     <= 1'b1;
            valid_r     <= 1'b0;
            rdata_r     <= 32'd0;
            err_r       <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= 32'd0;
            ram_wdata_r <= 32'd0;
        end else begin
            state_r     <= state_nx_s;
            ready_r     <= ready_nx_s;
            valid_r     <= valid_nx_s;
            rdata_r     <= rdata_nx_s;
            err_r       <= err_nx_s;
            ram_we_r    <= ram_we_nx_s;
            ram_addr_r  <= ram_addr_nx_s;
            ram_wdata_r <= ram_wdata_nx_s;
        end
    end

    // Request fields held for the ACCESS/WRITE phases.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_r      <= 1'b0;
            f3_r      <= 3'd0;
            addr_lo_r <= 2'd0;
            wdata_r   <= 32'd0;
        end else if (accept_s) begin
            we_r      <= req_we_i;
            f3_r      <= req_funct3_i;
            addr_lo_r <= req_addr_i[1:0];
            wdata_r   <= req_wdata_i;
        end
    end

    assign req_ready_o = ready_r;
    assign rsp_valid_o = valid_r;
    assign rsp_rdata_o = rdata_r;
    assign rsp_err_o   = err_r;
    // Reset kills a write already on the bus in the same cycle.
    assign ram_we_o    = ram_we_r && rst_n;
    assign ram_addr_o  = ram_addr_r;
    assign ram_wdata_o = ram_wdata_r;

endmodule
